// File: rtl/binary_down_counter.sv
// Synchronous, parallel-loadable binary down counter with zero flag and one-cycle borrow pulse.
// Define BINARY_DOWN_COUNTER_AUTORELOAD_EN to reload from the last loaded value on wrap instead of all-ones.
module binary_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             toggle,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] A,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] wrap_value;

`ifdef BINARY_DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_value;

  // Remembers the most recent load so a wrap from 0 restarts the timer period.
  always_ff @(posedge clock) begin
    if (reset) begin
      reload_value <= '0;
    end else if (load) begin
      reload_value <= D;
    end
  end

  assign wrap_value = reload_value;
`else
  assign wrap_value = '1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      A      <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      A      <= D;
      borrow <= 1'b0;
    end else if (toggle) begin
      if (A == '0) begin
        A      <= wrap_value;
        borrow <= 1'b1;
      end else begin
        A      <= A - 1'b1;
        borrow <= 1'b0;
      end
    end else begin
      borrow <= 1'b0;
    end
  end

  assign zero = (A == '0);

endmodule
